// File: rtl/ysyx_22040632_div_unit_pkg.sv
// Shared definitions for the RV64M divide path.
//   RV_XLEN     : architectural register width
//   DIV_CNT_W   : width of the divider iteration counter (holds 0..XLEN)
//   div_state_t : divider FSM state encoding
package ysyx_22040632_riscv_pkg;
  localparam int RV_XLEN   = 64;
  localparam int DIV_CNT_W = $clog2(RV_XLEN) + 1;

  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_t;
endpackage

// File: rtl/ysyx_22040632_div_unit_if.sv
// Divide request/response bundle between the EX stage and the divider.
//   cpu modport : EX side, drives the request, flush, and reads the results
//   div modport : divider side, mirror of cpu
//   div_valid/div_ready : request handshake
//   dividend/divisor/div_signed/divw : operands and controls, sampled at handshake
//   flush : synchronous abort
//   out_valid/quotient/remainder : single-cycle result pulse, results held after
interface ysyx_22040632_divif
  import ysyx_22040632_riscv_pkg::*;
#(
  parameter int XLEN = RV_XLEN
);
  logic            div_valid;
  logic            div_ready;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            div_signed;
  logic            divw;
  logic            flush;
  logic            out_valid;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  modport cpu (
    output div_valid, dividend, divisor, div_signed, divw, flush,
    input  div_ready, out_valid, quotient, remainder
  );

  modport div (
    input  div_valid, dividend, divisor, div_signed, divw, flush,
    output div_ready, out_valid, quotient, remainder
  );
endinterface

// File: rtl/ysyx_22040632_div_unit.sv
// Multi-cycle radix-2 restoring divider for RV64M div/divu/rem/remu and the
// W-forms. One quotient bit per cycle, MSB first; divide-by-zero and signed
// overflow finish after a single cycle.
//   clk  : core clock
//   rrst : asynchronous reset, active-high
//   bus  : divide interface (div modport), see ysyx_22040632_divif
module ysyx_22040632_div_unit
  import ysyx_22040632_riscv_pkg::*;
#(
  parameter int XLEN = RV_XLEN
) (
  input  logic                   clk,
  input  logic                   rrst,
  ysyx_22040632_divif.div        bus
);

  localparam int HW    = XLEN / 2;
  localparam int CNT_W = $clog2(XLEN) + 1;

  // Take the low half and extend it to XLEN, signed or zero.
  function automatic logic [XLEN-1:0] ext_w(input logic [XLEN-1:0] v, input logic s);
    return {{HW{s & v[HW-1]}}, v[HW-1:0]};
  endfunction

  function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [XLEN-1:0] abs_v(input logic [XLEN-1:0] v, input logic s);
    return s ? neg(v) : v;
  endfunction

  // One restoring step: returns {next rem, next quo}. The dividend bit
  // shifted out of quo's MSB enters the partial remainder, the new quotient
  // bit enters quo's LSB.
  function automatic logic [2*XLEN-1:0] div_step(input logic [XLEN-1:0] r,
                                                 input logic [XLEN-1:0] q,
                                                 input logic [XLEN-1:0] d);
    logic [XLEN:0] part, diff;
    part = {r, q[XLEN-1]};
    diff = part - {1'b0, d};
    if (diff[XLEN]) return {part[XLEN-1:0], q[XLEN-2:0], 1'b0};
    return {diff[XLEN-1:0], q[XLEN-2:0], 1'b1};
  endfunction

  div_state_t       state;
  logic [XLEN-1:0]  rem, quo, dvsr;
  logic [CNT_W-1:0] cnt;
  logic             neg_q, neg_r, divw_q;

  // Request decode (only meaningful at the handshake).
  logic [XLEN-1:0] op_a, op_b, abs_a, abs_b, a_res, most_neg;
  logic            sa, sb, b_zero, ovf;

  always_comb begin
    op_a     = bus.divw ? ext_w(bus.dividend, bus.div_signed) : bus.dividend;
    op_b     = bus.divw ? ext_w(bus.divisor,  bus.div_signed) : bus.divisor;
    sa       = bus.div_signed & op_a[XLEN-1];
    sb       = bus.div_signed & op_b[XLEN-1];
    abs_a    = abs_v(op_a, sa);
    abs_b    = abs_v(op_b, sb);
    // W results are always sign-extended, even for the unsigned forms.
    a_res    = bus.divw ? ext_w(bus.dividend, 1'b1) : bus.dividend;
    // Most-negative value after extension to XLEN.
    most_neg = bus.divw ? {{(HW+1){1'b1}}, {(HW-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    b_zero   = (op_b == '0);
    ovf      = bus.div_signed & (op_a == most_neg) & (op_b == '1);
  end

  // Datapath step plus the sign/width fix-up used on the final step.
  logic [XLEN-1:0] step_rem, step_quo, q_fix, r_fix;

  always_comb begin
    {step_rem, step_quo} = div_step(rem, quo, dvsr);
    q_fix = neg_q ? neg(step_quo) : step_quo;
    r_fix = neg_r ? neg(step_rem) : step_rem;
    if (divw_q) begin
      q_fix = ext_w(q_fix, 1'b1);
      r_fix = ext_w(r_fix, 1'b1);
    end
  end

  always_ff @(posedge clk or posedge rrst) begin
    if (rrst) begin
      state  <= DIV_IDLE;
      rem    <= '0;
      quo    <= '0;
      dvsr   <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      divw_q <= 1'b0;
    end else if (bus.flush) begin
      state <= DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE: if (bus.div_valid) begin
          divw_q <= bus.divw;
          neg_q  <= sa ^ sb;
          neg_r  <= sa;
          dvsr   <= abs_b;
          cnt    <= bus.divw ? CNT_W'(HW) : CNT_W'(XLEN);
          if (b_zero) begin
            quo   <= '1;
            rem   <= a_res;
            state <= DIV_DONE;
          end else if (ovf) begin
            quo   <= a_res;
            rem   <= '0;
            state <= DIV_DONE;
          end else begin
            // W-form magnitudes sit in the upper half so the MSB-first
            // shift starts at dividend bit 31.
            quo   <= bus.divw ? (abs_a << HW) : abs_a;
            rem   <= '0;
            state <= DIV_CALC;
          end
        end
        DIV_CALC: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            quo   <= q_fix;
            rem   <= r_fix;
            state <= DIV_DONE;
          end else begin
            quo <= step_quo;
            rem <= step_rem;
          end
        end
        DIV_DONE: state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

  assign bus.div_ready = (state == DIV_IDLE);
  assign bus.out_valid = (state == DIV_DONE);
  assign bus.quotient  = quo;
  assign bus.remainder = rem;

endmodule

// File: tb/tb_ysyx_22040632_div_unit.sv
// Directed and randomised checks of the RV64M restoring divider.
module tb_ysyx_22040632_div_unit;
  logic clk = 1'b0;
  logic rrst;
  int   n_chk = 0;
  int   n_fail = 0;

  ysyx_22040632_divif #(.XLEN(64)) bus ();

  ysyx_22040632_div_unit #(.XLEN(64)) dut (
    .clk  (clk),
    .rrst (rrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference: plain SV arithmetic plus the RISC-V special-case rules.
  function automatic void ref_div(input logic [63:0] a, input logic [63:0] b,
                                  input logic s, input logic w,
                                  output logic [63:0] q, output logic [63:0] r);
    logic [31:0] a32, b32, q32, r32;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 32'd0) begin q32 = '1; r32 = a32; end
      else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = '0; end
      else if (s) begin q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32); end
      else begin q32 = a32 / b32; r32 = a32 % b32; end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0) begin q = '1; r = a; end
      else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; r = '0; end
      else if (s) begin q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); end
      else begin q = a / b; r = a % b; end
    end
  endfunction

  // Called at a negedge while the divider is idle; returns at the negedge of
  // the cycle after the handshake (cycle 1). Operand inputs are scrambled
  // afterwards so late sampling would show up.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic s, input logic w);
    bus.dividend   = a;
    bus.divisor    = b;
    bus.div_signed = s;
    bus.divw       = w;
    bus.div_valid  = 1'b1;
    @(negedge clk);
    bus.div_valid  = 1'b0;
    bus.dividend   = {$urandom, $urandom};
    bus.divisor    = {$urandom, $urandom};
    bus.div_signed = ~s;
    bus.divw       = ~w;
  endtask

  // Waits (bounded) for out_valid; lat is the cycle number it was seen in.
  task automatic wait_done(output int lat, output bit rdy_bad);
    lat = 1;
    rdy_bad = 1'b0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.div_ready) rdy_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (bus.div_ready) rdy_bad = 1'b1;
  endtask

  task automatic test_reset();
    rrst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (bus.div_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.div_ready); end
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    n_chk++; if (bus.quotient !== 64'd0 || bus.remainder !== 64'd0) begin n_fail++;
      $display("FAIL reset_results: got q=%h r=%h want 0/0", bus.quotient, bus.remainder); end
    rrst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_divu_basic();
    int lat; bit rb;
    issue(64'd100, 64'd7, 1'b0, 1'b0);
    wait_done(lat, rb);
    n_chk++; if (lat !== 65) begin n_fail++; $display("FAIL divu_latency: got %0d want 65", lat); end
    n_chk++; if (rb !== 1'b0) begin n_fail++; $display("FAIL divu_ready_busy: got ready high while busy, want low"); end
    n_chk++; if (bus.quotient !== 64'd14 || bus.remainder !== 64'd2) begin n_fail++;
      $display("FAIL divu_100_7: got q=%h r=%h want 14/2", bus.quotient, bus.remainder); end
    @(negedge clk);
    n_chk++; if (bus.out_valid !== 1'b0 || bus.div_ready !== 1'b1) begin n_fail++;
      $display("FAIL divu_pulse_width: got valid=%b ready=%b want 0/1", bus.out_valid, bus.div_ready); end
    n_chk++; if (bus.quotient !== 64'd14 || bus.remainder !== 64'd2) begin n_fail++;
      $display("FAIL divu_hold: got q=%h r=%h want 14/2", bus.quotient, bus.remainder); end
  endtask

  task automatic test_signed();
    int lat; bit rb;
    issue(-64'sd7, 64'd2, 1'b1, 1'b0);
    wait_done(lat, rb);
    n_chk++; if (bus.quotient !== 64'hFFFF_FFFF_FFFF_FFFD || bus.remainder !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++;
      $display("FAIL div_m7_2: got q=%h r=%h want -3/-1", bus.quotient, bus.remainder); end
    @(negedge clk);
    issue(64'd7, -64'sd2, 1'b1, 1'b0);
    wait_done(lat, rb);
    n_chk++; if (bus.remainder !== 64'd1 || bus.quotient !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++;
      $display("FAIL rem_7_m2: got q=%h r=%h want -3/1", bus.quotient, bus.remainder); end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    int lat; bit rb;
    issue(64'd5, 64'd0, 1'b0, 1'b0);
    wait_done(lat, rb);
    n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL dz_latency: got %0d want 1", lat); end
    n_chk++; if (bus.quotient !== '1 || bus.remainder !== 64'd5) begin n_fail++;
      $display("FAIL divu_5_0: got q=%h r=%h want all-ones/5", bus.quotient, bus.remainder); end
    @(negedge clk);
    issue(64'h0000_0000_8000_0001, 64'hABCD_0000_0000_0000, 1'b1, 1'b1);
    wait_done(lat, rb);
    n_chk++; if (bus.remainder !== 64'hFFFF_FFFF_8000_0001 || lat !== 1) begin n_fail++;
      $display("FAIL remw_dz: got r=%h lat=%0d want ffffffff80000001 lat=1", bus.remainder, lat); end
    @(negedge clk);
  endtask

  task automatic test_overflow();
    int lat; bit rb;
    issue(64'h8000_0000_0000_0000, '1, 1'b1, 1'b0);
    wait_done(lat, rb);
    n_chk++; if (bus.quotient !== 64'h8000_0000_0000_0000 || bus.remainder !== 64'd0 || lat !== 1) begin n_fail++;
      $display("FAIL div_ovf: got q=%h r=%h lat=%0d want 8000000000000000/0 lat=1", bus.quotient, bus.remainder, lat); end
    @(negedge clk);
    issue(64'h0000_0000_8000_0000, '1, 1'b1, 1'b1);
    wait_done(lat, rb);
    n_chk++; if (bus.quotient !== 64'hFFFF_FFFF_8000_0000 || bus.remainder !== 64'd0 || lat !== 1) begin n_fail++;
      $display("FAIL divw_ovf: got q=%h r=%h lat=%0d want ffffffff80000000/0 lat=1", bus.quotient, bus.remainder, lat); end
    @(negedge clk);
  endtask

  task automatic test_w_unsigned();
    int lat; bit rb;
    issue(64'hDEAD_BEEF_FFFF_FFFF, 64'h1234_5678_0000_0001, 1'b0, 1'b1);
    wait_done(lat, rb);
    n_chk++; if (lat !== 33) begin n_fail++; $display("FAIL divuw_latency: got %0d want 33", lat); end
    n_chk++; if (bus.quotient !== '1 || bus.remainder !== 64'd0) begin n_fail++;
      $display("FAIL divuw_ffffffff_1: got q=%h r=%h want all-ones/0", bus.quotient, bus.remainder); end
    @(negedge clk);
  endtask

  task automatic test_flush();
    int lat; bit rb; bit seen;
    // flush together with a request in IDLE: not accepted
    bus.flush = 1'b1;
    issue(64'd9, 64'd0, 1'b0, 1'b0);
    bus.flush = 1'b0;
    seen = 1'b0;
    repeat (3) begin if (bus.out_valid) seen = 1'b1; @(negedge clk); end
    n_chk++; if (seen !== 1'b0 || bus.div_ready !== 1'b1) begin n_fail++;
      $display("FAIL flush_idle_req: got valid_seen=%b ready=%b want 0/1", seen, bus.div_ready); end
    // flush in CALC cycle 10
    issue(64'd1000, 64'd3, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    n_chk++; if (bus.div_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL flush_calc: got ready=%b valid=%b want 1/0", bus.div_ready, bus.out_valid); end
    seen = 1'b0;
    repeat (70) begin if (bus.out_valid) seen = 1'b1; @(negedge clk); end
    n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_valid: got out_valid after flush, want none"); end
    issue(64'd9, 64'd3, 1'b0, 1'b0);
    wait_done(lat, rb);
    n_chk++; if (bus.quotient !== 64'd3 || bus.remainder !== 64'd0 || lat !== 65) begin n_fail++;
      $display("FAIL after_flush_9_3: got q=%h r=%h lat=%0d want 3/0 lat=65", bus.quotient, bus.remainder, lat); end
    @(negedge clk);
  endtask

  task automatic test_rrst();
    issue(64'h0123_4567_89AB_CDEF, 64'd5, 1'b0, 1'b0);
    repeat (19) @(negedge clk);
    #2 rrst = 1'b1;
    #1;
    n_chk++; if (bus.div_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.quotient !== 64'd0 || bus.remainder !== 64'd0) begin
      n_fail++; $display("FAIL rrst_mid: got ready=%b valid=%b q=%h r=%h want 1/0/0/0",
                         bus.div_ready, bus.out_valid, bus.quotient, bus.remainder); end
    @(negedge clk);
    rrst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat; bit rb;
    issue(64'd5, 64'd0, 1'b0, 1'b0);
    wait_done(lat, rb);
    @(negedge clk);
    n_chk++; if (bus.div_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL b2b_idle: got ready=%b valid=%b want 1/0", bus.div_ready, bus.out_valid); end
    issue(64'd9, 64'd3, 1'b0, 1'b0);
    wait_done(lat, rb);
    n_chk++; if (bus.quotient !== 64'd3 || bus.remainder !== 64'd0 || lat !== 65) begin n_fail++;
      $display("FAIL b2b_9_3: got q=%h r=%h lat=%0d want 3/0 lat=65", bus.quotient, bus.remainder, lat); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, want_lat, f; bit rb, spec;
    logic [63:0] a, b, eq, er;
    logic s, w;
    for (int i = 0; i < 300; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      s = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: b = 64'd0;
        1: begin a = w ? 64'h8000_0000 : 64'h8000_0000_0000_0000; b = '1; end
        2: b = 64'($urandom_range(1, 20));
        3: b = b >> $urandom_range(1, 63);
        default: ;
      endcase
      ref_div(a, b, s, w, eq, er);
      spec = w ? (b[31:0] == 32'd0 || (s && a[31:0] == 32'h8000_0000 && b[31:0] == '1))
               : (b == 64'd0 || (s && a == 64'h8000_0000_0000_0000 && b == '1));
      want_lat = spec ? 1 : (w ? 33 : 65);
      issue(a, b, s, w);
      if (!spec && $urandom_range(0, 7) == 0) begin
        f = $urandom_range(1, want_lat - 2);
        repeat (f - 1) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        n_chk++; if (bus.div_ready !== 1'b1 || bus.out_valid !== 1'b0) begin n_fail++;
          $display("FAIL rand_flush %0d: got ready=%b valid=%b want 1/0", i, bus.div_ready, bus.out_valid); end
      end else begin
        wait_done(lat, rb);
        n_chk++; if (bus.quotient !== eq || bus.remainder !== er || lat !== want_lat) begin n_fail++;
          $display("FAIL rand_op %0d: a=%h b=%h s=%b w=%b got q=%h r=%h lat=%0d want q=%h r=%h lat=%0d",
                   i, a, b, s, w, bus.quotient, bus.remainder, lat, eq, er, want_lat); end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    bus.div_valid  = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    bus.div_signed = 1'b0;
    bus.divw       = 1'b0;
    bus.flush      = 1'b0;
    rrst           = 1'b1;
    @(negedge clk);
    test_reset();
    test_divu_basic();
    test_signed();
    test_div_zero();
    test_overflow();
    test_w_unsigned();
    test_flush();
    test_rrst();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
